ngram_query_encoder: RTL and testbench
======================================

Name: ngram_query_encoder

Overview:
- Temporal N-gram encoder that produces query hypervectors for the associative memory.
- Accepts a stream of spatial hypervectors over a Valid/Ready handshake and keeps the last NGRAM_SIZE of them in a history register.
- Binds the history as newest XOR rho(previous) XOR rho^2(...) and so on, then presents the registered N-gram on a Valid/Ready handshake whose downstream end is the AM's ValidIn_SI/ReadyOut_SO.
- FlushIn_SI restarts the window at trial boundaries.

Parameters:
- HV_DIMENSION, default `HV_DIMENSION (2000): hypervector width in bits, indexed [0:HV_DIMENSION-1].
- NGRAM_SIZE, default 3: number of consecutive inputs bound per query; legal range 1..8.

Ports:
- Clk_CI  input  1  clock, all state changes on the rising edge.
- Reset_RBI  input  1  asynchronous, active-low reset.
- ValidIn_SI  input  1  upstream spatial hypervector valid.
- ReadyOut_SO  output  1  encoder can accept an input this cycle.
- HypervectorIn_DI  input  HV_DIMENSION  spatial hypervector.
- FlushIn_SI  input  1  one-cycle pulse that discards the history window.
- ValidOut_SO  output  1  query hypervector valid (drives AM ValidIn_SI).
- ReadyIn_SI  input  1  downstream ready (driven by AM ReadyOut_SO).
- HypervectorOut_DO  output  HV_DIMENSION  registered N-gram query.
- FillCnt_SO  output  ceilLog2(NGRAM_SIZE+1)  number of valid history entries, for debug.

Behaviour:
- Reset (Reset_RBI=0, asynchronous) puts the block in these values, held until the first rising edge after release:
  - state IDLE;
  - history entries H[0..NGRAM_SIZE-1] all zero;
  - FillCnt = 0;
  - HypervectorOut_DO = 0;
  - ValidOut_SO = 0;
  - ReadyOut_SO = 0 while reset is asserted.
- Rotation: rho(x)[i] = x[(i-1) mod HV_DIMENSION], i.e. a one-position circular shift toward higher index; bit HV_DIMENSION-1 wraps to bit 0. rho^k means rho applied k times.
- N-gram: Q = H[0] ^ rho(H[1]) ^ ... ^ rho^(N-1)(H[N-1]), where H[0] is the newest input. This is pure bitwise XOR, with no carries or width growth.
- States:
  - IDLE: ReadyOut_SO = !FlushIn_SI, ValidOut_SO = 0.
    - Accept when ValidIn_SI && ReadyOut_SO: shift the history (H[k] <= H[k-1], H[0] <= HypervectorIn_DI) and set FillCnt <= min(FillCnt+1, NGRAM_SIZE).
    - If the post-accept FillCnt equals NGRAM_SIZE: register Q (computed on the post-shift history) into HypervectorOut_DO and go to OUTPUT_STABLE.
    - Otherwise stay in IDLE (warm-up; no output).
  - OUTPUT_STABLE: ValidOut_SO = 1, ReadyOut_SO = 0, and HypervectorOut_DO holds stable.
    - If ReadyIn_SI = 1 the transfer completes that cycle and the next state is IDLE; otherwise the block stays in OUTPUT_STABLE.
- Latency and throughput:
  - ValidOut_SO rises on the cycle after the accepting edge.
  - Maximum throughput is one query per 2 cycles.
  - After warm-up, every accepted input yields exactly one query (sliding window, stride 1).
- Flush:
  - In IDLE, FlushIn_SI=1 forces ReadyOut_SO low that cycle; no input is accepted. On the edge, history is zeroed and FillCnt is set to 0. Flush takes priority over ValidIn_SI.
  - In OUTPUT_STABLE, flush zeroes the history and FillCnt, but the pending query and ValidOut_SO are kept until handed off.
- NGRAM_SIZE = 1: Q = H[0]. Every accepted input is emitted unchanged, one cycle later, with no warm-up.
- Downstream stall: ValidOut_SO must not drop and HypervectorOut_DO must not change until ReadyIn_SI is seen. No input is accepted while stalled, so there is no overwrite and no loss.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronously). Any pending query is discarded.
- FillCnt_SO equals FillCnt: it saturates at NGRAM_SIZE and returns to 0 on flush or reset.

Test Plan:
Bench configuration for all scenarios: HV_DIMENSION=8, NGRAM_SIZE=3; hex values show bit 0 as the MSB.
- Warm-up: with ReadyIn=1, feed 0x80, 0x00, 0x00 on consecutive accepts -> no ValidOut after the first two inputs; after the third, ValidOut=1 for one cycle with HypervectorOut=0x20 (rho^2 of 0x80); FillCnt steps 1, 2, 3.
- Sliding window: continuing, feed 0x01 -> output 0x01; then feed 0x00 -> output 0x80 (rho(0x01) wraps bit 7 to bit 0).
- Backpressure: hold ReadyIn=0 for 5 cycles while a query is pending -> ValidOut stays 1, HypervectorOut is constant, ReadyOut=0 with ValidIn=1 and no accept. Raising ReadyIn -> one handshake, then IDLE with ReadyOut=1.
- Flush: after 2 inputs (FillCnt=2), pulse FlushIn together with ValidIn=1 -> input not accepted, FillCnt=0. Next, 3 inputs of 0xFF -> output 0xFF (0xFF ^ 0xFF ^ 0xFF).
- Reset mid-stall: while in OUTPUT_STABLE, assert Reset_RBI=0 between clock edges -> ValidOut and HypervectorOut go to 0 before the next edge; after release, a fresh 3-input warm-up is required.
- NGRAM_SIZE=1 instance: feed 0x5A then 0xC3 with ReadyIn=1 -> outputs 0x5A and 0xC3, each one cycle after its accept.

Source files
------------

// File: rtl/ngram_query_encoder.sv
// Temporal N-gram encoder: keeps a sliding window of spatial hypervectors and
// emits newest ^ rho(prev) ^ rho^2(...) as a registered query over Valid/Ready.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif

module ngram_query_encoder #(
    parameter int HV_DIMENSION = `HV_DIMENSION,
    parameter int NGRAM_SIZE   = 3,
    localparam int FillW       = $clog2(NGRAM_SIZE + 1)
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RBI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    input  logic                    FlushIn_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
    output logic [FillW-1:0]        FillCnt_SO
);

    typedef logic [0:HV_DIMENSION-1] hv_t;
    typedef enum logic [0:0] {IDLE = 1'b0, OUTPUT_STABLE = 1'b1} state_e;

    localparam logic [FillW-1:0] FillMax = FillW'(NGRAM_SIZE);

    // One-position circular shift toward higher index; last bit wraps to bit 0.
    function automatic hv_t rho(input hv_t x);
        return {x[HV_DIMENSION-1], x[0:HV_DIMENSION-2]};
    endfunction

    state_e           state_q, state_d;
    hv_t              hist_q    [NGRAM_SIZE];
    hv_t              hist_d    [NGRAM_SIZE];
    hv_t              shifted_s [NGRAM_SIZE];
    hv_t              query_s;
    hv_t              hv_q, hv_d;
    logic             valid_q, valid_d;
    logic [FillW-1:0] fill_q, fill_d, fill_inc_s;
    logic             accept_s;

    assign ReadyOut_SO       = Reset_RBI && (state_q == IDLE) && !FlushIn_SI;
    assign accept_s          = ValidIn_SI && ReadyOut_SO;
    assign fill_inc_s        = (fill_q == FillMax) ? fill_q : fill_q + FillW'(1);
    assign ValidOut_SO       = valid_q;
    assign HypervectorOut_DO = hv_q;
    assign FillCnt_SO        = fill_q;

    // Window as it would look after accepting the current input, and its binding.
    always_comb begin
        hv_t term;
        term         = '0;
        shifted_s[0] = HypervectorIn_DI;
        for (int k = 1; k < NGRAM_SIZE; k++) begin
            shifted_s[k] = hist_q[k-1];
        end
        query_s = '0;
        for (int k = 0; k < NGRAM_SIZE; k++) begin
            term = shifted_s[k];
            for (int r = 0; r < k; r++) begin
                term = rho(term);
            end
            query_s = query_s ^ term;
        end
    end

    // Next-state logic; a flush clears the window but never a pending query.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        hv_d    = hv_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (FlushIn_SI) begin
                    for (int k = 0; k < NGRAM_SIZE; k++) begin
                        hist_d[k] = '0;
                    end
                    fill_d = '0;
                end else if (accept_s) begin
                    hist_d = shifted_s;
                    fill_d = fill_inc_s;
                    if (fill_inc_s == FillMax) begin
                        hv_d    = query_s;
                        valid_d = 1'b1;
                        state_d = OUTPUT_STABLE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            OUTPUT_STABLE: begin
                if (FlushIn_SI) begin
                    for (int k = 0; k < NGRAM_SIZE; k++) begin
                        hist_d[k] = '0;
                    end
                    fill_d = '0;
                end else begin
                    fill_d = fill_q;
                end
                if (ReadyIn_SI) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    valid_d = 1'b1;
                    state_d = OUTPUT_STABLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, window, fill count and output registers.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q <= IDLE;
            for (int k = 0; k < NGRAM_SIZE; k++) begin
                hist_q[k] <= '0;
            end
            fill_q  <= '0;
            hv_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            hv_q    <= hv_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_ngram_query_encoder.sv
// Bench: N=3 and N=1 encoders (HV_DIMENSION=8) against a sliding-window model
// with a per-cycle compare plus hand-computed directed expectations.
module tb_ngram_query_encoder;

    logic       clk;
    logic       rst_n;
    logic       va, fa, ra, vb, fb, rb;
    logic [0:7] da, db;
    logic       rdy_a, vo_a, rdy_b, vo_b;
    logic [0:7] ho_a, ho_b;
    logic [1:0] fc_a;
    logic [0:0] fc_b;

    int n_chk;
    int n_fail;

    // Model state per unit (0: N=3, 1: N=1); mh[u][0] is the newest input.
    logic [0:7] mh [2][8];
    int         mcnt [2];
    logic       mv [2];
    logic [0:7] mo [2];

    ngram_query_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(3)) dut_a (
        .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(va), .ReadyOut_SO(rdy_a),
        .HypervectorIn_DI(da), .FlushIn_SI(fa), .ValidOut_SO(vo_a),
        .ReadyIn_SI(ra), .HypervectorOut_DO(ho_a), .FillCnt_SO(fc_a)
    );

    ngram_query_encoder #(.HV_DIMENSION(8), .NGRAM_SIZE(1)) dut_b (
        .Clk_CI(clk), .Reset_RBI(rst_n), .ValidIn_SI(vb), .ReadyOut_SO(rdy_b),
        .HypervectorIn_DI(db), .FlushIn_SI(fb), .ValidOut_SO(vo_b),
        .ReadyIn_SI(rb), .HypervectorOut_DO(ho_b), .FillCnt_SO(fc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Q[i] = XOR over k of H[k][(i-k) mod 8], straight from the rotation definition.
    function automatic logic [0:7] ngram(input int u, input int n);
        logic [0:7] q;
        q = 8'h00;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                q[i] = q[i] ^ mh[u][k][(i - k + 64) % 8];
            end
        end
        return q;
    endfunction

    task automatic model_clear();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 8; k++) mh[u][k] = 8'h00;
            mcnt[u] = 0;
            mv[u]   = 1'b0;
            mo[u]   = 8'h00;
        end
    endtask

    task automatic mstep(input int u, input int n, input logic v, input logic [0:7] d,
                         input logic f, input logic r);
        if (mv[u]) begin
            if (f) mcnt[u] = 0;
            if (r) mv[u] = 1'b0;
        end else if (f) begin
            mcnt[u] = 0;
        end else if (v) begin
            for (int k = 7; k > 0; k--) mh[u][k] = mh[u][k-1];
            mh[u][0] = d;
            if (mcnt[u] < n) mcnt[u] = mcnt[u] + 1;
            if (mcnt[u] == n) begin
                mo[u] = ngram(u, n);
                mv[u] = 1'b1;
            end
        end
    endtask

    // One clock: drive unit u (the other idles), advance the model, end on negedge.
    task automatic cyc(input int u, input logic v, input logic [0:7] d, input logic f, input logic r);
        #1;
        if (u == 0) begin
            va = v; da = d; fa = f; ra = r;
            vb = 1'b0; db = 8'h00; fb = 1'b0; rb = 1'b1;
        end else begin
            vb = v; db = d; fb = f; rb = r;
            va = 1'b0; da = 8'h00; fa = 1'b0; ra = 1'b1;
        end
        @(posedge clk);
        if (rst_n) begin
            mstep(0, 3, va, da, fa, ra);
            mstep(1, 1, vb, db, fb, rb);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        check("a_valid", 8'(vo_a), 8'(mv[0]));
        check("a_out",   8'(ho_a), 8'(mo[0]));
        check("a_fill",  8'(fc_a), 8'(mcnt[0]));
        check("a_ready", 8'(rdy_a), 8'(rst_n && !mv[0] && !fa));
        check("b_valid", 8'(vo_b), 8'(mv[1]));
        check("b_out",   8'(ho_b), 8'(mo[1]));
        check("b_fill",  8'(fc_b), 8'(mcnt[1]));
        check("b_ready", 8'(rdy_b), 8'(rst_n && !mv[1] && !fb));
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        model_clear();
        rst_n = 1'b0;
        va = 1'b0; da = 8'h00; fa = 1'b0; ra = 1'b1;
        vb = 1'b0; db = 8'h00; fb = 1'b0; rb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 8'(vo_a), 8'h00);
        check("rst_out",   8'(ho_a), 8'h00);
        check("rst_fill",  8'(fc_a), 8'h00);
        check("rst_ready", 8'(rdy_a), 8'h00);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Warm-up
        cyc(0, 1'b1, 8'h80, 1'b0, 1'b1);
        check("warm1_fill", 8'(fc_a), 8'h01);
        check("warm1_valid", 8'(vo_a), 8'h00);
        cyc(0, 1'b1, 8'h00, 1'b0, 1'b1);
        check("warm2_fill", 8'(fc_a), 8'h02);
        check("warm2_valid", 8'(vo_a), 8'h00);
        cyc(0, 1'b1, 8'h00, 1'b0, 1'b1);
        check("warm3_fill", 8'(fc_a), 8'h03);
        check("warm3_valid", 8'(vo_a), 8'h01);
        check("warm3_out", 8'(ho_a), 8'h20);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("hs1_valid", 8'(vo_a), 8'h00);

        // Sliding window
        cyc(0, 1'b1, 8'h01, 1'b0, 1'b1);
        check("slide1_out", 8'(ho_a), 8'h01);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("slide2_out", 8'(ho_a), 8'h80);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b1, 8'h55, 1'b0, 1'b0);
            check("stall_valid", 8'(vo_a), 8'h01);
            check("stall_out",   8'(ho_a), 8'h80);
            check("stall_ready", 8'(rdy_a), 8'h00);
        end
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("release_valid", 8'(vo_a), 8'h00);
        check("release_ready", 8'(rdy_a), 8'h01);

        // Flush
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("flush0_fill", 8'(fc_a), 8'h00);
        cyc(0, 1'b1, 8'hAA, 1'b0, 1'b1);
        cyc(0, 1'b1, 8'h55, 1'b0, 1'b1);
        check("pre_flush_fill", 8'(fc_a), 8'h02);
        cyc(0, 1'b1, 8'h11, 1'b1, 1'b1);
        check("flush_fill",  8'(fc_a), 8'h00);
        check("flush_valid", 8'(vo_a), 8'h00);
        check("flush_ready", 8'(rdy_a), 8'h00);
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 8'hFF, 1'b0, 1'b1);
        check("ff_valid", 8'(vo_a), 8'h01);
        check("ff_out",   8'(ho_a), 8'hFF);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset while stalled
        cyc(0, 1'b1, 8'h12, 1'b0, 1'b0);
        cyc(0, 1'b1, 8'h34, 1'b0, 1'b0);
        cyc(0, 1'b1, 8'h56, 1'b0, 1'b0);
        cyc(0, 1'b1, 8'h77, 1'b0, 1'b0);
        check("pre_rst_valid", 8'(vo_a), 8'h01);
        #2;
        rst_n = 1'b0;
        va = 1'b0; ra = 1'b1;
        model_clear();
        #1;
        check("midrst_valid", 8'(vo_a), 8'h00);
        check("midrst_out",   8'(ho_a), 8'h00);
        check("midrst_fill",  8'(fc_a), 8'h00);
        check("midrst_ready", 8'(rdy_a), 8'h00);
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        cyc(0, 1'b1, 8'h01, 1'b0, 1'b1);
        check("rewarm1_valid", 8'(vo_a), 8'h00);
        cyc(0, 1'b1, 8'h02, 1'b0, 1'b1);
        check("rewarm2_valid", 8'(vo_a), 8'h00);
        cyc(0, 1'b1, 8'h04, 1'b0, 1'b1);
        check("rewarm3_valid", 8'(vo_a), 8'h01);
        check("rewarm3_out",   8'(ho_a), 8'h45);
        cyc(0, 1'b0, 8'h00, 1'b0, 1'b1);

        // NGRAM_SIZE = 1
        cyc(1, 1'b1, 8'h5A, 1'b0, 1'b1);
        check("n1_a_valid", 8'(vo_b), 8'h01);
        check("n1_a_out",   8'(ho_b), 8'h5A);
        check("n1_a_fill",  8'(fc_b), 8'h01);
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("n1_hs_valid", 8'(vo_b), 8'h00);
        cyc(1, 1'b1, 8'hC3, 1'b0, 1'b1);
        check("n1_b_valid", 8'(vo_b), 8'h01);
        check("n1_b_out",   8'(ho_b), 8'hC3);
        cyc(1, 1'b0, 8'h00, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
